mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage access controller of the 16-bit pipelined processor. It consumes the EX/MEM pipeline register outputs and runs loads and stores against a variable-latency data memory using a req/ack handshake. It stalls the upstream pipeline while an access is outstanding. It registers the MEM/WB pipeline fields consumed by write-back.

## Interface
- TIMEOUT, 15, maximum ACCESS cycles without ack before abort; legal range 1..255
- clock  in  1  clock; all state changes on posedge
- reset  in  1  reset, synchronous, active-low
- op_mem_write_mem  in  1  EX/MEM store request
- op_mem_read_mem  in  1  EX/MEM load request
- op_reg_write_mem  in  1  EX/MEM register-write enable
- op_reg_write_address_mem  in  1  EX/MEM write-address select
- op_mdr_mem  in  1  EX/MEM select-MDR-for-write-back
- op_res_mem  in  1  EX/MEM select-result-for-write-back
- rd_mem  in  3  EX/MEM destination register
- ar_mem  in  16  EX/MEM ALU result / memory address
- data_register_mem  in  16  EX/MEM store data
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1 = write, 0 = read, registered
- dmem_addr  out  16  memory address, registered
- dmem_wdata  out  16  store data, registered
- dmem_ack  in  1  memory completion; qualifies dmem_rdata
- dmem_rdata  in  16  load data
- stall  out  1  combinational; hold PC, IF/ID, ID/EX, EX/MEM
- mem_error  out  1  one-cycle pulse on timeout abort, registered
- op_reg_write_wb, op_reg_write_address_wb, op_mdr_wb, op_res_wb  out  1 each  MEM/WB control
- rd_wb  out  3  MEM/WB destination register
- ar_wb  out  16  MEM/WB ALU result
- mdr_wb  out  16  MEM/WB load data

## Operation
- mem_op = op_mem_read_mem | op_mem_write_mem. If both are set, the access is a write and the read is ignored.
- States: IDLE and ACCESS. There is an 8-bit wait counter, cnt.
- IDLE, no mem_op:
  - stall = 0.
  - At the edge, MEM/WB loads all control bits, rd and ar from the inputs.
  - mdr_wb holds its value.
- IDLE, mem_op:
  - stall = 1.
  - At the edge, go to ACCESS with dmem_req = 1, dmem_we = op_mem_write_mem, dmem_addr = ar_mem, dmem_wdata = data_register_mem and cnt = 0.
  - MEM/WB control bits load 0 (bubble).
- ACCESS, dmem_ack = 1:
  - stall = 0.
  - At the edge, MEM/WB loads the held EX/MEM fields.
  - For a read, mdr_wb loads dmem_rdata. For a write, mdr_wb holds.
  - dmem_req goes to 0 and the state returns to IDLE.
- ACCESS, no ack, cnt < TIMEOUT-1:
  - stall = 1.
  - cnt increments.
  - MEM/WB control bits load 0.
  - Memory outputs hold stable.
- ACCESS, no ack, cnt == TIMEOUT-1 (timeout):
  - stall = 0.
  - At the edge, dmem_req goes to 0, mem_error = 1 for one cycle, and the state returns to IDLE.
  - MEM/WB loads rd and ar.
  - All MEM/WB control bits load 0, so the faulting instruction is squashed.
  - mdr_wb loads 0.
- ack and timeout in the same cycle: ack wins.
- dmem_ack while in IDLE: ignored.
- During a stall, EX/MEM is held upstream, so the held instruction is seen again in the next cycle. This block does not latch EX/MEM fields other than the memory outputs.

## Timing
- Reset, applied at any edge:
  - State goes to IDLE and cnt to 0.
  - dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_error and all MEM/WB outputs go to 0.
  - An in-flight access is abandoned and a late ack is ignored.
- Non-memory instruction: 1 cycle, no stall.
- Memory instruction with ack in the first ACCESS cycle: 2 cycles, one stall cycle.
  - Instruction presented in cycle N.
  - dmem_req is high in N+1.
  - MEM/WB is valid after the N+1 edge.
- Ack after k ACCESS cycles: k+1 cycles, k stall cycles.
- Worst case: dmem_req stays high for TIMEOUT cycles.
- mem_error is asserted in the cycle after the TIMEOUT-th ACCESS cycle.
- Handshake rules:
  - dmem_req stays high until the ack cycle or the timeout cycle completes.
  - dmem_addr, dmem_we and dmem_wdata are constant while dmem_req is high.
  - A new request requires at least one IDLE cycle, so dmem_req always drops for at least one cycle between accesses.
- Write-back sees each instruction's op_reg_write_wb = 1 for exactly one cycle.

## Test plan
- Reset: drive reset = 0 with random inputs and dmem_ack = 1 -> all outputs 0 and stall = 0 after the edge.
- Pass-through: inputs op_reg_write_mem = 1, rd_mem = 3, ar_mem = 0x1234, no mem_op -> next cycle rd_wb = 3, ar_wb = 0x1234, op_reg_write_wb = 1, stall never high.
- Load with 3-cycle ack:
  - Stimulus: read with ar_mem = 0x0040; dmem_ack arrives in the 3rd ACCESS cycle with dmem_rdata = 0xBEEF.
  - dmem_req is high for 3 cycles with dmem_addr = 0x0040 and dmem_we = 0.
  - stall is high for 3 cycles.
  - After completion mdr_wb = 0xBEEF, and op_reg_write_wb is 1 for one cycle only.
- Zero-wait store: write with ar_mem = 0x0010, data_register_mem = 0x00FF, dmem_ack in the first ACCESS cycle -> dmem_we = 1, dmem_wdata = 0x00FF, exactly one stall cycle, mdr_wb unchanged.
- Timeout with TIMEOUT = 4 and no ack:
  - dmem_req is high for 4 cycles.
  - mem_error pulses once and op_reg_write_wb = 0.
  - A following ALU instruction then passes through normally.
- Reset mid-access: reset = 0 in the 2nd ACCESS cycle, then dmem_ack = 1 one cycle after reset is released -> state IDLE, dmem_req = 0, the late ack is ignored, and mdr_wb = 0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: issues EX/MEM loads/stores to a req/ack data
// memory, stalls the upstream pipeline while busy and registers the MEM/WB fields.
module mem_access_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_mem_write_mem,
  input  logic        op_mem_read_mem,
  input  logic        op_reg_write_mem,
  input  logic        op_reg_write_address_mem,
  input  logic        op_mdr_mem,
  input  logic        op_res_mem,
  input  logic [2:0]  rd_mem,
  input  logic [15:0] ar_mem,
  input  logic [15:0] data_register_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic        stall,
  output logic        mem_error,
  output logic        op_reg_write_wb,
  output logic        op_reg_write_address_wb,
  output logic        op_mdr_wb,
  output logic        op_res_wb,
  output logic [2:0]  rd_wb,
  output logic [15:0] ar_wb,
  output logic [15:0] mdr_wb
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  // {reg_write, reg_write_address, mdr, res}
  logic [3:0]  wb_ctrl_q, wb_ctrl_d;
  logic [2:0]  rd_wb_q, rd_wb_d;
  logic [15:0] ar_wb_q, ar_wb_d;
  logic [15:0] mdr_wb_q, mdr_wb_d;

  logic       mem_op;
  logic [3:0] ctrl_in;

  assign mem_op  = op_mem_read_mem | op_mem_write_mem;
  assign ctrl_in = {op_reg_write_mem, op_reg_write_address_mem, op_mdr_mem, op_res_mem};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = 1'b0;
    wb_ctrl_d = 4'b0000;
    rd_wb_d   = rd_wb_q;
    ar_wb_d   = ar_wb_q;
    mdr_wb_d  = mdr_wb_q;
    stall     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          stall   = 1'b1;
          state_d = ACCESS;
          req_d   = 1'b1;
          we_d    = op_mem_write_mem;
          addr_d  = ar_mem;
          wdata_d = data_register_mem;
          cnt_d   = 8'd0;
        end else begin
          wb_ctrl_d = ctrl_in;
          rd_wb_d   = rd_mem;
          ar_wb_d   = ar_mem;
        end
      end
      ACCESS: begin
        // EX/MEM is frozen upstream during the stall, so the live inputs are the held instruction
        if (dmem_ack) begin
          wb_ctrl_d = ctrl_in;
          rd_wb_d   = rd_mem;
          ar_wb_d   = ar_mem;
          if (!we_q) mdr_wb_d = dmem_rdata;
          req_d     = 1'b0;
          state_d   = IDLE;
        end else if (cnt_q == LAST_WAIT) begin
          rd_wb_d  = rd_mem;
          ar_wb_d  = ar_mem;
          mdr_wb_d = 16'h0000;
          req_d    = 1'b0;
          err_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      err_q     <= 1'b0;
      wb_ctrl_q <= 4'b0000;
      rd_wb_q   <= 3'd0;
      ar_wb_q   <= 16'h0000;
      mdr_wb_q  <= 16'h0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      wb_ctrl_q <= wb_ctrl_d;
      rd_wb_q   <= rd_wb_d;
      ar_wb_q   <= ar_wb_d;
      mdr_wb_q  <= mdr_wb_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign mem_error  = err_q;

  assign {op_reg_write_wb, op_reg_write_address_wb, op_mdr_wb, op_res_wb} = wb_ctrl_q;
  assign rd_wb  = rd_wb_q;
  assign ar_wb  = ar_wb_q;
  assign mdr_wb = mdr_wb_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver issues instructions and acts as the
// memory; a monitor pops expected MEM/WB results as each instruction retires.
module tb_mem_access_unit;

  localparam int T = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        op_mem_write_mem, op_mem_read_mem;
  logic        op_reg_write_mem, op_reg_write_address_mem, op_mdr_mem, op_res_mem;
  logic [2:0]  rd_mem;
  logic [15:0] ar_mem, data_register_mem;
  logic        dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;
  logic        stall, mem_error;
  logic        op_reg_write_wb, op_reg_write_address_wb, op_mdr_wb, op_res_wb;
  logic [2:0]  rd_wb;
  logic [15:0] ar_wb, mdr_wb;

  always #5 clock = ~clock;

  mem_access_unit #(.TIMEOUT(T)) dut (
    .clock(clock), .reset(reset),
    .op_mem_write_mem(op_mem_write_mem), .op_mem_read_mem(op_mem_read_mem),
    .op_reg_write_mem(op_reg_write_mem), .op_reg_write_address_mem(op_reg_write_address_mem),
    .op_mdr_mem(op_mdr_mem), .op_res_mem(op_res_mem),
    .rd_mem(rd_mem), .ar_mem(ar_mem), .data_register_mem(data_register_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .mem_error(mem_error),
    .op_reg_write_wb(op_reg_write_wb), .op_reg_write_address_wb(op_reg_write_address_wb),
    .op_mdr_wb(op_mdr_wb), .op_res_wb(op_res_wb),
    .rd_wb(rd_wb), .ar_wb(ar_wb), .mdr_wb(mdr_wb)
  );

  typedef struct {
    logic [3:0]  ctrl;
    logic [2:0]  rd;
    logic [15:0] ar;
    logic [15:0] mdr;
    logic        err;
    int          stalls;
    int          reqs;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  bit          mon_en = 0;
  logic [15:0] mdr_model;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected results come from the instruction's own rules: latency k acks in
  // the k-th access cycle; anything beyond T access cycles is a timeout.
  task automatic issue(input logic rdq, input logic wrq, input logic [3:0] ctrl,
                       input logic [2:0] rd, input logic [15:0] ar, input logic [15:0] data,
                       input logic [15:0] rdata, input int k);
    exp_t e;
    bit   done;
    e.ctrl = ctrl; e.rd = rd; e.ar = ar; e.err = 1'b0;
    e.we = wrq; e.addr = ar; e.wdata = data;
    if (!(rdq | wrq)) begin
      e.stalls = 0; e.reqs = 0; e.mdr = mdr_model;
    end else if (k >= 1 && k <= T) begin
      e.stalls = k; e.reqs = k;
      if (!wrq) mdr_model = rdata;
      e.mdr = mdr_model;
    end else begin
      e.stalls = T; e.reqs = T; e.ctrl = 4'b0000; e.err = 1'b1;
      mdr_model = 16'h0000; e.mdr = 16'h0000;
    end
    @(negedge clock);
    sb.push_back(e);
    op_mem_read_mem = rdq; op_mem_write_mem = wrq;
    {op_reg_write_mem, op_reg_write_address_mem, op_mdr_mem, op_res_mem} = ctrl;
    rd_mem = rd; ar_mem = ar; data_register_mem = data;
    dmem_ack = 1'b0; dmem_rdata = rdata;
    @(posedge clock);
    if (rdq | wrq) begin
      done = 0;
      for (int j = 1; j <= 300 && !done; j++) begin
        @(negedge clock);
        dmem_ack = (j == k);
        #1;
        if (!stall) done = 1;
        @(posedge clock);
      end
      if (!done) chk("drive_bound", 32'd0, 32'd1);
    end
  endtask

  task automatic idle_inputs();
    op_mem_read_mem = 0; op_mem_write_mem = 0;
    {op_reg_write_mem, op_reg_write_address_mem, op_mdr_mem, op_res_mem} = 4'b0000;
    rd_mem = 0; ar_mem = 0; data_register_mem = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic flush();
    @(negedge clock);
    idle_inputs();
    repeat (3) @(negedge clock);
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic random_instrs(input int n);
    logic       r, w;
    logic [3:0] c;
    int         sel;
    for (int i = 0; i < n; i++) begin
      sel = int'($urandom_range(0, 3));
      r = (sel == 1) || (sel == 3 && $urandom_range(0, 1) == 1);
      w = (sel == 2) || (sel == 3);
      c = 4'($urandom);
      issue(r, w, c, 3'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            int'($urandom_range(1, T + 2)));
    end
  endtask

  // Monitor: a cycle with stall low retires the front instruction; its MEM/WB
  // values are visible one cycle later.
  initial begin : monitor
    exp_t e;
    bit   pending;
    bit   prev_stall;
    int   n_stall, n_req, cap_stall, cap_req;
    pending = 0; prev_stall = 0; n_stall = 0; n_req = 0; cap_stall = 0; cap_req = 0;
    forever begin
      @(negedge clock);
      #2;
      if (!mon_en) begin
        pending = 0; prev_stall = 0; n_stall = 0; n_req = 0;
      end else begin
        if (pending) begin
          e = sb.pop_front();
          $display("[TB] txn rd=%0d ar=0x%04h ctrl=%b mdr=0x%04h err=%0d stalls=%0d reqs=%0d",
                   rd_wb, ar_wb, {op_reg_write_wb, op_reg_write_address_wb, op_mdr_wb, op_res_wb},
                   mdr_wb, mem_error, cap_stall, cap_req);
          chk("wb_ctrl", 32'({op_reg_write_wb, op_reg_write_address_wb, op_mdr_wb, op_res_wb}),
              32'(e.ctrl));
          chk("rd_wb", 32'(rd_wb), 32'(e.rd));
          chk("ar_wb", 32'(ar_wb), 32'(e.ar));
          chk("mdr_wb", 32'(mdr_wb), 32'(e.mdr));
          chk("mem_error", 32'(mem_error), 32'(e.err));
          chk("stall_cycles", 32'(cap_stall), 32'(e.stalls));
          chk("req_cycles", 32'(cap_req), 32'(e.reqs));
          pending = 0;
        end else begin
          if (mem_error) chk("mem_error_spurious", 32'(mem_error), 32'd0);
          if (prev_stall)
            chk("bubble_ctrl", 32'({op_reg_write_wb, op_reg_write_address_wb, op_mdr_wb, op_res_wb}),
                32'd0);
        end
        if (sb.size() > 0) begin
          if (dmem_req) begin
            n_req++;
            chk("dmem_we", 32'(dmem_we), 32'(sb[0].we));
            chk("dmem_addr", 32'(dmem_addr), 32'(sb[0].addr));
            if (sb[0].we) chk("dmem_wdata", 32'(dmem_wdata), 32'(sb[0].wdata));
          end
          if (stall) n_stall++;
          else begin
            pending = 1; cap_stall = n_stall; cap_req = n_req; n_stall = 0; n_req = 0;
          end
        end
        prev_stall = stall;
      end
    end
  end

  initial begin : driver
    // Reset with random inputs and a stray ack
    reset = 1'b0;
    op_mem_read_mem = 1'b1; op_mem_write_mem = 1'($urandom);
    {op_reg_write_mem, op_reg_write_address_mem, op_mdr_mem, op_res_mem} = 4'($urandom);
    rd_mem = 3'($urandom); ar_mem = 16'($urandom); data_register_mem = 16'($urandom);
    dmem_ack = 1'b1; dmem_rdata = 16'($urandom);
    repeat (3) @(posedge clock);
    @(negedge clock);
    op_mem_read_mem = 1'b0; op_mem_write_mem = 1'b0;
    #1;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_addr", 32'(dmem_addr), 32'd0);
    chk("rst_wdata", 32'(dmem_wdata), 32'd0);
    chk("rst_err", 32'(mem_error), 32'd0);
    chk("rst_wb_ctrl", 32'({op_reg_write_wb, op_reg_write_address_wb, op_mdr_wb, op_res_wb}), 32'd0);
    chk("rst_rd_wb", 32'(rd_wb), 32'd0);
    chk("rst_ar_wb", 32'(ar_wb), 32'd0);
    chk("rst_mdr_wb", 32'(mdr_wb), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    idle_inputs();
    mdr_model = 16'h0000;
    mon_en = 1;

    issue(0, 0, 4'b1000, 3'd3, 16'h1234, 16'h0000, 16'h0000, 0);       // pass-through
    issue(1, 0, 4'b1010, 3'd5, 16'h0040, 16'h0000, 16'hBEEF, 3);       // load, ack in 3rd cycle
    issue(0, 1, 4'b0000, 3'd1, 16'h0010, 16'h00FF, 16'h5555, 1);       // zero-wait store
    issue(1, 0, 4'b1010, 3'd2, 16'h0080, 16'h0000, 16'h1111, T + 1);   // timeout
    issue(0, 0, 4'b1001, 3'd6, 16'h2222, 16'h0000, 16'h0000, 0);       // ALU after timeout
    issue(1, 1, 4'b0001, 3'd7, 16'h0090, 16'hA5A5, 16'h7777, 2);       // both set: write
    issue(1, 0, 4'b1010, 3'd4, 16'h00A0, 16'h0000, 16'hC0DE, T);       // ack on last cycle
    random_instrs(60);
    flush();

    // Reset in the 2nd access cycle, then a late ack after release
    mon_en = 0;
    @(negedge clock);
    op_mem_read_mem = 1'b1; ar_mem = 16'h0077; op_reg_write_mem = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    idle_inputs();
    #1;
    chk("midrst_req", 32'(dmem_req), 32'd0);
    @(negedge clock);
    dmem_ack = 1'b1; dmem_rdata = 16'hDEAD;
    #1;
    chk("midrst_stall", 32'(stall), 32'd0);
    @(negedge clock);
    dmem_ack = 1'b0;
    #1;
    chk("midrst_req_after_ack", 32'(dmem_req), 32'd0);
    chk("midrst_mdr", 32'(mdr_wb), 32'd0);
    chk("midrst_err", 32'(mem_error), 32'd0);
    mdr_model = 16'h0000;
    mon_en = 1;

    random_instrs(20);
    flush();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
